// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline enable/flush/bubble control for load-use, taken branch and multi-cycle MUL
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16,
  parameter int ZR_IDX  = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_rn_used,
  input  logic             id_rm_used,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mul,
  input  logic             ex_br_taken,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int          MC_W     = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT);
  localparam bit          MUL_EN   = (MUL_LAT >= 2);
  localparam logic [4:0]  ZR       = 5'(ZR_IDX);
  localparam logic [MC_W-1:0] MUL_INIT = MUL_EN ? MC_W'(MUL_LAT - 2) : '0;

  typedef enum logic {RUN, MUL_WAIT} state_t;

  state_t           state_q, state_d;
  logic [MC_W-1:0]  mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             luse;

  assign luse = ex_mem_read && (ex_rd != ZR) &&
                ((id_rn_used && (id_rn == ex_rd)) || (id_rm_used && (id_rm == ex_rd)));

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    state_d       = state_q;
    mul_cnt_d     = mul_cnt_q;
    stall_cnt_d   = stall_cnt_q;

    if (reset) begin
      unique case (state_q)
        RUN: begin
          if (ex_br_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (ex_mul && MUL_EN) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_bubble = 1'b1;
            state_d       = MUL_WAIT;
            mul_cnt_d     = MUL_INIT;
          end else if (luse) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        MUL_WAIT: begin
          // ID is frozen behind the MUL, so hazards seen here are stale
          if (mul_cnt_q != '0) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_bubble = 1'b1;
            mul_cnt_d     = mul_cnt_q - 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase

      if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RUN;
      mul_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mul_cnt_q   <= mul_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
